garbage_sender: RTL and testbench
=================================

# garbage_sender

Attack transmitter for two-player mode: counts rows cleared on the local board and delivers each one as a garbage row to the opponent's board controller. It drives the opponent's `send_en`, `bomb_pos` and `get_line` inputs and uses the opponent's `mode` as the handshake return path. One instance exists per direction: P1→P2 and P2→P1.

## Interface
Parameters:
- `BLOCKS_ROW`, default 10: board width; `bomb_pos` is always in 0..BLOCKS_ROW-1.
- `QUEUE_DEPTH`, default 7: maximum number of pending attacks held; the pending counter is 3 bits.
- `MAX_LINES`, default 8: maximum value of `get_line`.
- `LFSR_SEED`, default 4'b1011: LFSR value after reset; must be non-zero.

Ports:
- `clk` input 1: system clock, the same clock as the board controllers.
- `rst` input 1: **asynchronous, active-low** reset.
- `clr` input 1: synchronous clear; driven from `time_up | state_rst`.
- `remove_row_en` input 1: the local board's row-complete request, as a level.
- `opp_mode` input `MODE_BITS`: the opponent board's current mode.
- `send_en` output 1: attack request to the opponent.
- `bomb_pos` output 4: column of the garbage hole.
- `get_line` output `BITS_Y_POS`: number of garbage rows currently on the opponent's board.
- `pending` output 3: number of queued attacks not yet sent.

## Operation
- **Row event:** a rising edge of `remove_row_en`, detected with a one-flop delay.
- **Pending counter:**
  - Increments on a row event and saturates at QUEUE_DEPTH; further events are dropped.
  - Decrements on acknowledge.
  - A row event and an acknowledge in the same cycle leave the count unchanged.
- **LFSR:** 4-bit, polynomial x^4+x^3+1, advances every cycle.
  - Candidate column = LFSR value if it is below BLOCKS_ROW, otherwise LFSR − BLOCKS_ROW, with a further correction if still out of range.
- **FSM states:** IDLE, REQ, BUSY.
  - IDLE → REQ when `pending != 0` and `get_line < MAX_LINES`. On this transition the candidate column is latched into `bomb_pos`.
  - In REQ, `send_en` = 1. `bomb_pos` stays stable.
  - REQ → BUSY when `opp_mode == MODE_GET` (the acknowledge). In that cycle `send_en` falls, `pending` decrements and `get_line` increments.
  - BUSY → IDLE when `opp_mode == MODE_PLAY`.
  - While `opp_mode` is MODE_PAUSE, MODE_DROP or MODE_SHIFT, REQ holds indefinitely and `send_en` stays high.
- **Garbage removal:** on every cycle where `opp_mode` enters MODE_CLEAR (previous cycle's value was a different mode), `get_line` decrements, floored at 0. This is independent of FSM state.
  - If this coincides with an acknowledge, the increment and decrement cancel.
- **Full condition:** `get_line == MAX_LINES` blocks IDLE → REQ. Pending attacks are retained until room appears.
- **`clr`:** state → IDLE, `pending` → 0, `get_line` → 0, `send_en` → 0. The LFSR is not affected. `clr` overrides every other event in the same cycle.

## Timing
- Reset values: `send_en` 0, `bomb_pos` 0, `get_line` 0, `pending` 0, state IDLE, LFSR = LFSR_SEED, edge flop 0, previous-mode register MODE_IDLE.
- All outputs are registered.
- Latency with the opponent already in MODE_PLAY:
  - Row event detected at cycle N.
  - `pending` = 1 at N+1.
  - `send_en` high at N+2.
- The acknowledge is sampled on the `opp_mode` register value; `send_en` drops on the clock edge following the first MODE_GET cycle.
- Only one attack is in flight at a time. The next REQ can be issued no earlier than 1 cycle after the return to MODE_PLAY.
- Reset asserted mid-REQ: `send_en` drops asynchronously.

## Structure
- `MODE_*`, `MODE_BITS`, `BITS_Y_POS` and `BLOCKS_ROW` come from the shared `global.v`. Add `SEND_IDLE`, `SEND_REQ` and `SEND_BUSY` there as well.
- Sub-module `bomb_lfsr`: the 4-bit LFSR with range reduction, output `col[3:0]`.
- The FSM and counters stay in `garbage_sender`.

## Test plan
- Reset, then one `remove_row_en` pulse with `opp_mode` = PLAY → `send_en` high 2 cycles after the edge with `bomb_pos` < 10. Then drive `opp_mode` = GET → `send_en` 0, `get_line` = 1, `pending` = 0.
- 9 row events with `opp_mode` = PAUSE → `pending` saturates at 7 and `send_en` holds high. Then cycle GET/PLAY 7 times → `get_line` = 7, `pending` = 0.
- `get_line` = 8 (MAX_LINES) with `pending` = 2 → `send_en` stays 0. One MODE_CLEAR entry → `get_line` = 7, then `send_en` rises.
- Acknowledge (GET) in the same cycle as a row event → `pending` unchanged, `get_line` +1.
- `clr` pulsed during REQ with `get_line` = 3 → next cycle `send_en` 0, `get_line` 0, `pending` 0, state IDLE.
- `rst` driven low asynchronously mid-REQ → `send_en` falls before the next clock edge and all outputs take their reset values.

Source files
------------

// File: rtl/garbage_sender_pkg.sv
// garbage_sender_pkg: definitions shared by the garbage sender and the board
// controllers it talks to.
//   MODE_*       opponent board mode encodings (MODE_BITS wide)
//   BITS_Y_POS   width of row-count values such as get_line
//   BLOCKS_ROW   board width in columns
//   send_state_t sender FSM states (SEND_IDLE, SEND_REQ, SEND_BUSY)
package garbage_sender_pkg;

  localparam int MODE_BITS  = 3;
  localparam int BITS_Y_POS = 5;
  localparam int BLOCKS_ROW = 10;

  localparam logic [MODE_BITS-1:0] MODE_IDLE  = 3'd0;
  localparam logic [MODE_BITS-1:0] MODE_PLAY  = 3'd1;
  localparam logic [MODE_BITS-1:0] MODE_PAUSE = 3'd2;
  localparam logic [MODE_BITS-1:0] MODE_DROP  = 3'd3;
  localparam logic [MODE_BITS-1:0] MODE_SHIFT = 3'd4;
  localparam logic [MODE_BITS-1:0] MODE_GET   = 3'd5;
  localparam logic [MODE_BITS-1:0] MODE_CLEAR = 3'd6;

  typedef enum logic [1:0] {
    SEND_IDLE = 2'd0,
    SEND_REQ  = 2'd1,
    SEND_BUSY = 2'd2
  } send_state_t;

endpackage

// File: rtl/garbage_sender_if.sv
// garbage_sender_if: attack link between a garbage sender and the opponent's
// board controller.
//   send_en  sender -> board : attack request (acts as "valid")
//   bomb_pos sender -> board : hole column, stable while send_en is high
//   get_line sender -> board : garbage rows currently on the opponent board
//   opp_mode board -> sender : opponent mode, the handshake return path
// Handshake: send_en is a valid that, once raised, stays high with bomb_pos
// held until the board answers with opp_mode == MODE_GET (the "ready"); the
// attack transfers in that cycle. The sender then waits for MODE_PLAY before
// it may raise send_en again, so one attack at most is ever in flight.
interface garbage_sender_if;
  import garbage_sender_pkg::*;

  logic                  send_en;
  logic [3:0]            bomb_pos;
  logic [BITS_Y_POS-1:0] get_line;
  logic [MODE_BITS-1:0]  opp_mode;

  modport master (output send_en, output bomb_pos, output get_line, input opp_mode);
  modport slave  (input send_en, input bomb_pos, input get_line, output opp_mode);
endinterface

// File: rtl/garbage_sender_bomb_lfsr.sv
// bomb_lfsr: free-running 4-bit LFSR (x^4 + x^3 + 1) folded into a column
// index for the garbage hole.
//   clk  system clock
//   rst  asynchronous active-low reset (LFSR reloads LFSR_SEED)
//   col  candidate column, always in 0..BLOCKS_ROW-1
module bomb_lfsr #(
  parameter int         BLOCKS_ROW = 10,
  parameter logic [3:0] LFSR_SEED  = 4'b1011
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col
);

  localparam logic [4:0] BR1 = 5'(BLOCKS_ROW);
  localparam logic [4:0] BR2 = 5'(2 * BLOCKS_ROW);

  logic [3:0] lfsr;
  logic [4:0] val;
  logic [4:0] sub1;
  logic [4:0] sub2;

  // A non-zero seed keeps the register out of the all-zero lock-up state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  end

  assign val  = {1'b0, lfsr};
  assign sub1 = val - BR1;
  assign sub2 = val - BR2;

  // Subtract the width once, then once more for narrow boards; anything
  // still out of range falls back to column 0.
  always_comb begin
    col = 4'd0;
    if (val < BR1)                    col = lfsr;
    else if (sub1 < BR1)              col = sub1[3:0];
    else if (val >= BR2 && sub2 < BR1) col = sub2[3:0];
  end

endmodule

// File: rtl/garbage_sender.sv
// garbage_sender: counts rows cleared on the local board and delivers each as
// a garbage row to the opponent board controller.
//   clk           system clock (shared with the board controllers)
//   rst           asynchronous active-low reset
//   clr           synchronous clear (time_up | state_rst), overrides all else
//   remove_row_en local row-complete request, level; rising edge = one row
//   bus           master side of the attack link (send_en/bomb_pos/get_line
//                 out, opp_mode in)
//   pending       queued attacks not yet sent
//   state         current FSM state, exported for observation
module garbage_sender
  import garbage_sender_pkg::*;
#(
  parameter int         BLOCKS_ROW  = garbage_sender_pkg::BLOCKS_ROW,
  parameter int         QUEUE_DEPTH = 7,
  parameter int         MAX_LINES   = 8,
  parameter logic [3:0] LFSR_SEED   = 4'b1011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              remove_row_en,
  garbage_sender_if.master  bus,
  output logic [2:0]        pending,
  output send_state_t       state
);

  localparam logic [2:0]            DEPTH = 3'(QUEUE_DEPTH);
  localparam logic [BITS_Y_POS-1:0] LIMIT = BITS_Y_POS'(MAX_LINES);

  send_state_t          next_state;
  logic                 row_q;
  logic [MODE_BITS-1:0] mode_q;
  logic [3:0]           col;
  logic                 row_event;
  logic                 ack;
  logic                 clear_entry;

  bomb_lfsr #(.BLOCKS_ROW(BLOCKS_ROW), .LFSR_SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .col (col)
  );

  assign row_event   = remove_row_en & ~row_q;
  assign ack         = (state == SEND_REQ) && (bus.opp_mode == MODE_GET);
  assign clear_entry = (bus.opp_mode == MODE_CLEAR) && (mode_q != MODE_CLEAR);

  always_comb begin
    next_state = state;
    case (state)
      SEND_IDLE: if (pending != 3'd0 && bus.get_line < LIMIT) next_state = SEND_REQ;
      SEND_REQ:  if (bus.opp_mode == MODE_GET)                next_state = SEND_BUSY;
      SEND_BUSY: if (bus.opp_mode == MODE_PLAY)               next_state = SEND_IDLE;
      default:                                                next_state = SEND_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= SEND_IDLE;
    else if (clr) state <= SEND_IDLE;
    else          state <= next_state;
  end

  // Edge detector and previous-mode register run through clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q  <= 1'b0;
      mode_q <= MODE_IDLE;
    end else begin
      row_q  <= remove_row_en;
      mode_q <= bus.opp_mode;
    end
  end

  // send_en mirrors the registered state so it is glitch-free at the board.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.send_en  <= 1'b0;
      bus.bomb_pos <= 4'd0;
    end else if (clr) begin
      bus.send_en  <= 1'b0;
    end else begin
      bus.send_en <= (next_state == SEND_REQ);
      if (state == SEND_IDLE && next_state == SEND_REQ) bus.bomb_pos <= col;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              pending <= 3'd0;
    else if (clr)                          pending <= 3'd0;
    else if (row_event && ack)             pending <= pending;
    else if (row_event && pending < DEPTH) pending <= pending + 3'd1;
    else if (ack)                          pending <= pending - 3'd1;
  end

  // An acknowledge and a MODE_CLEAR entry in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     bus.get_line <= '0;
    else if (clr) bus.get_line <= '0;
    else if (ack && !clear_entry) bus.get_line <= bus.get_line + 1'b1;
    else if (!ack && clear_entry && bus.get_line != '0)
      bus.get_line <= bus.get_line - 1'b1;
  end

endmodule

// File: tb/tb_garbage_sender.sv
module tb_garbage_sender;
  import garbage_sender_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic clr;
  logic remove_row_en;
  logic [2:0]  pending;
  send_state_t state;

  garbage_sender_if bus ();

  garbage_sender dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .remove_row_en (remove_row_en),
    .bus           (bus),
    .pending       (pending),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [3:0] saved_pos;

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic row_pulse();
    remove_row_en = 1'b1;
    tick();
    remove_row_en = 1'b0;
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst           = 1'b0;
    clr           = 1'b0;
    remove_row_en = 1'b0;
    bus.opp_mode  = MODE_PLAY;
    tick();
    tick();
    check("rst_send_en",  32'(bus.send_en),  0);
    check("rst_bomb_pos", 32'(bus.bomb_pos), 0);
    check("rst_get_line", 32'(bus.get_line), 0);
    check("rst_pending",  32'(pending),      0);
    check("rst_state",    32'(state),        32'(SEND_IDLE));
    rst = 1'b1;
    tick();

    // Single attack with the opponent in PLAY.
    remove_row_en = 1'b1;
    tick();
    remove_row_en = 1'b0;
    check("t1_pending_n1", 32'(pending),     1);
    check("t1_send_n1",    32'(bus.send_en), 0);
    tick();
    check("t1_send_n2",    32'(bus.send_en), 1);
    check("t1_bomb_range", 32'(bus.bomb_pos < 4'd10), 1);
    saved_pos = bus.bomb_pos;
    tick();
    check("t1_bomb_stable", 32'(bus.bomb_pos), 32'(saved_pos));
    bus.opp_mode = MODE_GET;
    tick();
    check("t1_ack_send",    32'(bus.send_en),  0);
    check("t1_ack_line",    32'(bus.get_line), 1);
    check("t1_ack_pending", 32'(pending),      0);
    check("t1_ack_state",   32'(state),        32'(SEND_BUSY));
    bus.opp_mode = MODE_PLAY;
    tick();
    check("t1_back_idle",   32'(state),        32'(SEND_IDLE));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t1_clr_line",    32'(bus.get_line), 0);

    // Saturation with the opponent paused.
    bus.opp_mode = MODE_PAUSE;
    for (int i = 0; i < 9; i++) row_pulse();
    check("t2_pending_sat", 32'(pending),     7);
    check("t2_send_hold",   32'(bus.send_en), 1);
    check("t2_state_req",   32'(state),       32'(SEND_REQ));
    for (int i = 0; i < 7; i++) begin
      bus.opp_mode = MODE_GET;
      tick();
      check("t2_pending_dec", 32'(pending), 32'(6 - i));
      bus.opp_mode = MODE_PLAY;
      tick();
      tick();
    end
    check("t2_line7",    32'(bus.get_line), 7);
    check("t2_pending0", 32'(pending),      0);
    check("t2_send0",    32'(bus.send_en),  0);

    // Full board blocks requests until a MODE_CLEAR entry.
    row_pulse();
    remove_row_en = 1'b1;
    tick();
    remove_row_en = 1'b0;
    tick();
    remove_row_en = 1'b1;
    tick();
    remove_row_en = 1'b0;
    bus.opp_mode = MODE_GET;
    tick();
    check("t3_line8",     32'(bus.get_line), 8);
    check("t3_pending2",  32'(pending),      2);
    bus.opp_mode = MODE_PLAY;
    tick();
    tick();
    tick();
    check("t3_full_send", 32'(bus.send_en),  0);
    check("t3_full_idle", 32'(state),        32'(SEND_IDLE));
    check("t3_full_pend", 32'(pending),      2);
    bus.opp_mode = MODE_CLEAR;
    tick();
    check("t3_clear_line", 32'(bus.get_line), 7);
    check("t3_clear_send", 32'(bus.send_en),  0);
    tick();
    check("t3_clear_once", 32'(bus.get_line), 7);
    check("t3_send_rise",  32'(bus.send_en),  1);
    bus.opp_mode = MODE_PLAY;
    tick();
    check("t3_req_hold",   32'(bus.send_en),  1);

    // Acknowledge and row event in the same cycle.
    bus.opp_mode  = MODE_GET;
    remove_row_en = 1'b1;
    tick();
    check("t4_pending_same", 32'(pending),      2);
    check("t4_line_inc",     32'(bus.get_line), 8);
    check("t4_send0",        32'(bus.send_en),  0);
    remove_row_en = 1'b0;
    bus.opp_mode  = MODE_PLAY;
    tick();

    // clr during REQ with get_line = 3 (also overrides a row event).
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      row_pulse();
      bus.opp_mode = MODE_GET;
      tick();
      bus.opp_mode = MODE_PLAY;
      tick();
    end
    row_pulse();
    check("t5_pre_line", 32'(bus.get_line), 3);
    check("t5_pre_send", 32'(bus.send_en),  1);
    clr           = 1'b1;
    remove_row_en = 1'b1;
    tick();
    clr           = 1'b0;
    remove_row_en = 1'b0;
    check("t5_clr_send",    32'(bus.send_en),  0);
    check("t5_clr_line",    32'(bus.get_line), 0);
    check("t5_clr_pending", 32'(pending),      0);
    check("t5_clr_state",   32'(state),        32'(SEND_IDLE));
    tick();
    check("t5_stay_idle",   32'(state),        32'(SEND_IDLE));

    // Asynchronous reset in the middle of REQ.
    row_pulse();
    check("t6_pre_send", 32'(bus.send_en), 1);
    rst = 1'b0;
    #1;
    check("t6_async_send", 32'(bus.send_en),  0);
    check("t6_async_pos",  32'(bus.bomb_pos), 0);
    check("t6_async_line", 32'(bus.get_line), 0);
    check("t6_async_pend", 32'(pending),      0);
    check("t6_async_state", 32'(state),       32'(SEND_IDLE));
    tick();
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
